// File: rtl/gf16_pkg.sv
// gf16_pkg
// Shared GF(16) helpers for the masked-inverter checkers.
//
// Field: GF(2)[a]/(a^4 + a + 1), represented in the normal basis
// {b, b^2, b^4, b^8} with b = a^3. Bit i of a nibble is the coefficient of
// b^(2^i). In this basis the field one is the all-ones nibble, because
// b + b^2 + b^4 + b^8 = Tr(b) = 1.
//
// Contents:
//   GF16_ONE    field-one encoding
//   MAX_SHARES  largest share count that recombine() can fold
//   gf16_inv    multiplicative inverse, with 0 mapped to 0
//   recombine   XOR-fold of zero-padded 4-bit shares
package gf16_pkg;

    localparam logic [3:0] GF16_ONE   = 4'hF;
    localparam int         MAX_SHARES = 16;

    function automatic logic [3:0] gf16_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'h0;
            4'h1:    y = 4'h4;
            4'h2:    y = 4'h8;
            4'h3:    y = 4'hD;
            4'h4:    y = 4'h1;
            4'h5:    y = 4'hA;
            4'h6:    y = 4'hB;
            4'h7:    y = 4'hC;
            4'h8:    y = 4'h2;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'h5;
            4'hB:    y = 4'h6;
            4'hC:    y = 4'h7;
            4'hD:    y = 4'h3;
            4'hE:    y = 4'h9;
            default: y = 4'hF;
        endcase
        return y;
    endfunction

    // Callers zero-pad their SHARES nibbles up to MAX_SHARES. The unused
    // zero nibbles leave the XOR unchanged.
    function automatic logic [3:0] recombine(input logic [4*MAX_SHARES-1:0] shares);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < MAX_SHARES; i++) begin
            acc = acc ^ shares[4*i +: 4];
        end
        return acc;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line
// Fixed-depth shift register that carries a valid bit together with a data
// word. It has no stall, so it accepts one entry per clock.
// The asynchronous reset clears only the valid bits. Data words are
// don't-care whenever their valid bit is low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (valid bits only)
//   in_valid   valid bit pushed on each edge
//   in_data    data word pushed on each edge
//   out_valid  valid bit of the entry pushed DEPTH edges ago
//   out_data   data word of the entry pushed DEPTH edges ago
module valid_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] data [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data[i] <= data[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule

// File: rtl/dom_inverter_checker.sv
// dom_inverter_checker
// Receive-side monitor for the masked GF(16) inverter.
// It unmasks the input shares and delays that value by the inverter latency.
// It then unmasks the returned output shares and compares them against a
// reference inverse. Each check result is registered.
//
// Ports:
//   ClkxCI         rising-edge clock
//   RstxBI         asynchronous active-low reset
//   ClearxSI       synchronous clear of counters, fail flag and capture
//   InValidxSI     inverter input shares valid this cycle
//   _XxDI          inverter input shares, share i in [4i+3:4i]
//   _QxDI          inverter output shares, same packing
//   CheckValidxSO  a comparison result is presented this cycle
//   MismatchxSO    the presented result is wrong
//   XunmaskedxDO   unmasked input of the last checked item (held)
//   QunmaskedxDO   unmasked output of the last checked item (held)
//   CheckCntxDO    saturating count of completed checks
//   ErrCntxDO      saturating count of mismatches
//   FailxSO        sticky, set on the first mismatch
//   FirstErrXxDO   unmasked input of the first mismatch
//   FirstErrQxDO   unmasked output of the first mismatch
module dom_inverter_checker
    import gf16_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic                ClkxCI,
    input  logic                RstxBI,
    input  logic                ClearxSI,
    input  logic                InValidxSI,
    input  logic [4*SHARES-1:0] _XxDI,
    input  logic [4*SHARES-1:0] _QxDI,
    output logic                CheckValidxSO,
    output logic                MismatchxSO,
    output logic [3:0]          XunmaskedxDO,
    output logic [3:0]          QunmaskedxDO,
    output logic [CNT_W-1:0]    CheckCntxDO,
    output logic [CNT_W-1:0]    ErrCntxDO,
    output logic                FailxSO,
    output logic [3:0]          FirstErrXxDO,
    output logic [3:0]          FirstErrQxDO
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [4*MAX_SHARES-1:0] x_ext;
    logic [4*MAX_SHARES-1:0] q_ext;
    logic [3:0]              x_p0;
    logic [3:0]              q_p1;
    logic                    vld_p1;
    logic [3:0]              x_p1;
    logic                    mismatch_p1;

    always_comb begin
        x_ext = '0;
        q_ext = '0;
        x_ext[4*SHARES-1:0] = _XxDI;
        q_ext[4*SHARES-1:0] = _QxDI;
        x_p0 = recombine(x_ext);
        q_p1 = recombine(q_ext);
    end

    // ---- p0 -> p1: unmasked input travels through the latency-matched delay line
    valid_delay_line #(
        .DEPTH(LATENCY),
        .WIDTH(4)
    ) u_delay (
        .clk      (ClkxCI),
        .rst_n    (RstxBI),
        .in_valid (InValidxSI),
        .in_data  (x_p0),
        .out_valid(vld_p1),
        .out_data (x_p1)
    );

    assign mismatch_p1 = vld_p1 && (q_p1 != gf16_inv(x_p1));

    // ---- p1 -> p2: registered result, counters and first-error capture
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            CheckValidxSO <= 1'b0;
            MismatchxSO   <= 1'b0;
            XunmaskedxDO  <= 4'h0;
            QunmaskedxDO  <= 4'h0;
            CheckCntxDO   <= '0;
            ErrCntxDO     <= '0;
            FailxSO       <= 1'b0;
            FirstErrXxDO  <= 4'h0;
            FirstErrQxDO  <= 4'h0;
        end else begin
            CheckValidxSO <= vld_p1;
            MismatchxSO   <= mismatch_p1;
            if (vld_p1) begin
                XunmaskedxDO <= x_p1;
                QunmaskedxDO <= q_p1;
            end
            // A clear in the same cycle as a completing check still lets the
            // result show on CheckValid/Mismatch, but the result is not
            // accumulated.
            if (ClearxSI) begin
                CheckCntxDO  <= '0;
                ErrCntxDO    <= '0;
                FailxSO      <= 1'b0;
                FirstErrXxDO <= 4'h0;
                FirstErrQxDO <= 4'h0;
            end else if (vld_p1) begin
                CheckCntxDO <= sat_inc(CheckCntxDO);
                if (mismatch_p1) begin
                    ErrCntxDO <= sat_inc(ErrCntxDO);
                    if (!FailxSO) begin
                        FailxSO      <= 1'b1;
                        FirstErrXxDO <= x_p1;
                        FirstErrQxDO <= q_p1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dom_inverter_checker.sv
module tb_dom_inverter_checker;

    localparam int SH  = 2;
    localparam int LAT = 3;
    localparam logic [3:0] ONE_NB = 4'hF;

    typedef struct packed {
        logic       v;
        logic [3:0] x;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clr;
    logic            in_valid;
    logic [4*SH-1:0] x_sh;
    logic [4*SH-1:0] q_sh;

    logic        cv, mm, fail;
    logic [3:0]  xo, qo, fx, fq;
    logic [15:0] cnt, err;
    logic        cv_s, mm_s, fail_s;
    logic [3:0]  xo_s, qo_s, fx_s, fq_s;
    logic [1:0]  cnt_s, err_s;

    always #5 clk = ~clk;

    dom_inverter_checker #(.SHARES(SH), .LATENCY(LAT), .CNT_W(16)) dut (
        .ClkxCI(clk), .RstxBI(rst_n), .ClearxSI(clr), .InValidxSI(in_valid),
        ._XxDI(x_sh), ._QxDI(q_sh),
        .CheckValidxSO(cv), .MismatchxSO(mm), .XunmaskedxDO(xo), .QunmaskedxDO(qo),
        .CheckCntxDO(cnt), .ErrCntxDO(err), .FailxSO(fail),
        .FirstErrXxDO(fx), .FirstErrQxDO(fq)
    );

    dom_inverter_checker #(.SHARES(SH), .LATENCY(LAT), .CNT_W(2)) dut_s (
        .ClkxCI(clk), .RstxBI(rst_n), .ClearxSI(clr), .InValidxSI(in_valid),
        ._XxDI(x_sh), ._QxDI(q_sh),
        .CheckValidxSO(cv_s), .MismatchxSO(mm_s), .XunmaskedxDO(xo_s), .QunmaskedxDO(qo_s),
        .CheckCntxDO(cnt_s), .ErrCntxDO(err_s), .FailxSO(fail_s),
        .FirstErrXxDO(fx_s), .FirstErrQxDO(fq_s)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    item_t      pend[$];
    logic       e_cv, e_mm, e_fail;
    logic [3:0] e_x, e_q, e_fx, e_fq;
    int         e_cnt, e_err, e_cnt_s, e_err_s;

    // Field arithmetic in polynomial basis (a^4 + a + 1). Normal-basis
    // elements b^(2^i), b = a^3, are a^3, a^6, a^12, a^9.
    function automatic logic [3:0] nb2poly(input logic [3:0] n);
        logic [3:0] basis [4];
        logic [3:0] p;
        basis[0] = 4'h8; basis[1] = 4'hC; basis[2] = 4'hF; basis[3] = 4'hA;
        p = 4'h0;
        for (int i = 0; i < 4; i++) if (n[i]) p = p ^ basis[i];
        return p;
    endfunction

    function automatic logic [3:0] poly_mul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'({4'h0, a}) << i);
        for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    // Inverse by search: the y whose product with n is the field one.
    function automatic logic [3:0] ref_inv(input logic [3:0] n);
        logic [3:0] r;
        r = 4'h0;
        for (int y = 1; y < 16; y++) begin
            if (poly_mul(nb2poly(n), nb2poly(4'(y))) == nb2poly(ONE_NB)) r = 4'(y);
        end
        return r;
    endfunction

    function automatic logic [4*SH-1:0] split(input logic [3:0] x);
        logic [4*SH-1:0] s;
        logic [3:0]      acc;
        logic [3:0]      r;
        acc = x;
        s = '0;
        for (int i = 0; i < SH - 1; i++) begin
            r = 4'($urandom);
            s[4*i +: 4] = r;
            acc = acc ^ r;
        end
        s[4*(SH-1) +: 4] = acc;
        return s;
    endfunction

    function automatic logic [3:0] fold(input logic [4*SH-1:0] s);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < SH; i++) acc = acc ^ s[4*i +: 4];
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < LAT; i++) pend.push_back('{v: 1'b0, x: 4'h0});
        e_cv = 0; e_mm = 0; e_fail = 0;
        e_x = 0; e_q = 0; e_fx = 0; e_fq = 0;
        e_cnt = 0; e_err = 0; e_cnt_s = 0; e_err_s = 0;
    endtask

    task automatic check_all();
        chk("cv", 32'(cv), 32'(e_cv));
        chk("mm", 32'(mm), 32'(e_mm));
        chk("xo", 32'(xo), 32'(e_x));
        chk("qo", 32'(qo), 32'(e_q));
        chk("cnt", 32'(cnt), 32'(e_cnt));
        chk("err", 32'(err), 32'(e_err));
        chk("fail", 32'(fail), 32'(e_fail));
        chk("fx", 32'(fx), 32'(e_fx));
        chk("fq", 32'(fq), 32'(e_fq));
        chk("cnt_s", 32'(cnt_s), 32'(e_cnt_s));
        chk("err_s", 32'(err_s), 32'(e_err_s));
        chk("fail_s", 32'(fail_s), 32'(e_fail));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare.
    // inj flips bit 0 of share 1 of the output shares for the item completing now.
    task automatic step(input logic v, input logic [4*SH-1:0] xs, input logic inj,
                        input logic c, input logic r);
        item_t           ex;
        logic [3:0]      qt;
        logic [4*SH-1:0] flip;
        ex = pend[0];
        qt = ex.v ? ref_inv(ex.x) : 4'($urandom);
        flip = '0;
        flip[4] = inj;
        in_valid = v; x_sh = xs; clr = c; rst_n = r;
        q_sh = split(qt) ^ flip;
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            void'(pend.pop_front());
            pend.push_back('{v: v, x: fold(xs)});
            e_cv = ex.v;
            e_mm = ex.v & inj;
            if (ex.v) begin
                e_x = ex.x;
                e_q = qt ^ {3'b000, inj};
            end
            if (c) begin
                e_cnt = 0; e_err = 0; e_cnt_s = 0; e_err_s = 0;
                e_fail = 0; e_fx = 0; e_fq = 0;
            end else if (ex.v) begin
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt_s < 3) e_cnt_s++;
                if (inj) begin
                    if (e_err < 65535) e_err++;
                    if (e_err_s < 3) e_err_s++;
                    if (!e_fail) begin
                        e_fail = 1; e_fx = ex.x; e_fq = e_q;
                    end
                end
            end
        end
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, split(4'($urandom)), 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int         run;
        int         first_hi;
        logic [3:0] xv [10];
        logic [3:0] xr;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; x_sh = '0; q_sh = '0;
        model_reset();

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // X = 0 as shares {A,A}
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        idle(LAT);
        chk("x0_cv", 32'(cv), 32'd1);
        chk("x0_q", 32'(qo), 32'd0);
        chk("x0_mm", 32'(mm), 32'd0);
        chk("x0_cnt", 32'(cnt), 32'd1);

        // X = field one, random split
        step(1'b1, split(ONE_NB), 1'b0, 1'b0, 1'b1);
        idle(LAT);
        chk("one_q", 32'(qo), 32'(ONE_NB));
        chk("one_mm", 32'(mm), 32'd0);

        // 100 back-to-back random items after a clear
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        run = 0;
        first_hi = -1;
        for (int i = 0; i < 100 + LAT; i++) begin
            step(i < 100, split(4'($urandom)), 1'b0, 1'b0, 1'b1);
            if (cv === 1'b1) begin
                run++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk("b2b_run", 32'(run), 32'd100);
        chk("b2b_first", 32'(first_hi), 32'(LAT));
        chk("b2b_cnt", 32'(cnt), 32'd100);
        chk("b2b_err", 32'(err), 32'd0);
        chk("b2b_fail", 32'(fail), 32'd0);

        // Error injection on item 5, a second one on item 8
        for (int i = 0; i < 10; i++) xv[i] = 4'($urandom);
        for (int i = 0; i < 10 + LAT; i++) begin
            step(i < 10, split(xv[i % 10]), (i == 5 + LAT) || (i == 8 + LAT), 1'b0, 1'b1);
            if (i == 5 + LAT) begin
                chk("inj_mm", 32'(mm), 32'd1);
                chk("inj_err1", 32'(err), 32'd1);
                chk("inj_fail", 32'(fail), 32'd1);
                chk("inj_fx", 32'(fx), 32'(xv[5]));
            end
        end
        chk("inj_err2", 32'(err), 32'd2);
        chk("inj_fx_keep", 32'(fx), 32'(xv[5]));

        // Reset with two items in flight
        step(1'b1, split(4'($urandom)), 1'b0, 1'b0, 1'b1);
        step(1'b1, split(4'($urandom)), 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        run = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            step(1'b0, split(4'($urandom)), 1'b0, 1'b0, 1'b1);
            if (cv !== 1'b0) run++;
        end
        chk("rst_cv_seen", 32'(run), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Error, then a second error completing together with a clear
        for (int i = 0; i < LAT + 2; i++) begin
            xr = 4'($urandom);
            step(i < 2, split(xr), i >= LAT, i == LAT + 1, 1'b1);
            if (i == LAT) chk("clr_err_pre", 32'(err), 32'd1);
        end
        chk("clr_mm", 32'(mm), 32'd1);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_fail", 32'(fail), 32'd0);

        // Five errors: 2-bit counter saturates at 3
        for (int i = 0; i < 5 + LAT; i++) begin
            step(i < 5, split(4'($urandom)), i >= LAT, 1'b0, 1'b1);
        end
        chk("sat_err_s", 32'(err_s), 32'd3);
        chk("sat_err", 32'(err), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dom_inverter_checker.md
Name: dom_inverter_checker

Overview:
- Receive-side monitor for the masked GF(16) inverter. Sits next to the `inverter` instance in benches and FPGA self-test wrappers.
- Recombines the input shares it is given and delays the unmasked value by the inverter pipeline latency. It then recombines the returned output shares and compares them against a reference GF(16) inverse.
- Reports per-item results, a saturating error count, a sticky fail flag and a capture of the first mismatching operand.

Parameters:
- SHARES, 2, number of Boolean shares per 4-bit value; legal range >= 2.
- LATENCY, 3, cycles from an input sample to the corresponding valid output shares; must match the inverter configuration; legal range >= 1.
- CNT_W, 16, width of the check and error counters.

Ports:
- ClkxCI  in  1  clock; all state updates on the rising edge.
- RstxBI  in  1  asynchronous active-low reset.
- ClearxSI  in  1  synchronous clear of counters, fail flag and capture registers.
- InValidxSI  in  1  the inverter input shares are valid this cycle.
- _XxDI  in  4*SHARES  inverter input shares; share i occupies bits [4i+3:4i].
- _QxDI  in  4*SHARES  inverter output shares, same packing.
- CheckValidxSO  out  1  result of one comparison is valid this cycle.
- MismatchxSO  out  1  the result flagged by CheckValidxSO is wrong.
- XunmaskedxDO  out  4  recombined input of the checked item.
- QunmaskedxDO  out  4  recombined output of the checked item.
- CheckCntxDO  out  CNT_W  number of completed checks, saturating.
- ErrCntxDO  out  CNT_W  number of mismatches, saturating.
- FailxSO  out  1  sticky; set on the first mismatch.
- FirstErrXxDO  out  4  unmasked input of the first mismatch.
- FirstErrQxDO  out  4  unmasked output of the first mismatch.

Behaviour:
- Reset (RstxBI=0, asynchronous):
  - All outputs and counters go to 0.
  - The delay line valid bits are cleared, so in-flight items are dropped.
  - Deassertion takes effect synchronously; the first sample is taken at the next edge.
- Recombination: X = XOR over all shares of _XxDI; Q = XOR over all shares of _QxDI. Both are purely combinational before the registers.
- Delay line: on each edge push {InValidxSI, X} into a shift register of depth LATENCY. Accepts one item per cycle with no stall, as the inverter is fully pipelined.
- Compare timing:
  - An item sampled at edge t exits the delay line at edge t+LATENCY.
  - At that edge _QxDI is recombined and compared with gf16_inv(X_delayed).
  - The result is registered, so CheckValidxSO=1 in the cycle following edge t+LATENCY.
- Outputs when CheckValidxSO=1: XunmaskedxDO and QunmaskedxDO show the compared pair. MismatchxSO = (Q != gf16_inv(X)).
- Outputs when CheckValidxSO=0: MismatchxSO=0; the data outputs hold their last values.
- Counters:
  - CheckCntxDO increments on every valid check; ErrCntxDO increments on every mismatch.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Fail capture:
  - On a mismatch while FailxSO=0: set FailxSO and load FirstErrX/FirstErrQ.
  - Later mismatches do not overwrite the capture.
- ClearxSI=1:
  - Zeroes the counters, FailxSO and the capture registers. The delay line is not flushed.
  - If a check completes in the same cycle, clear wins: that result is still shown on CheckValidxSO/MismatchxSO but is not counted or captured.
- Share-randomness independence: the checker consumes only the recombined values, so any share split must give an identical result.

Decomposition:
- Shared package `gf16_pkg`:
  - GF16_ONE constant, the field-one encoding of the inverter's normal basis.
  - `gf16_inv` function as a 16-entry table in the same basis.
  - `recombine` function (XOR-fold of SHARES nibbles).
- One natural sub-module: `valid_delay_line` (parameters DEPTH and WIDTH; async active-low reset clears the valid bits only). It is reused for future S-box latency checkers.

Test Plan:
- X=0, split as shares {4'hA,4'hA}, fed to the inverter -> after LATENCY+1 cycles CheckValidxSO=1, Q=0, MismatchxSO=0, CheckCntxDO=1.
- X=GF16_ONE with random shares -> QunmaskedxDO=GF16_ONE, no mismatch.
- 100 back-to-back random items, one per cycle -> CheckCntxDO=100, ErrCntxDO=0, FailxSO=0. CheckValidxSO stays high for 100 consecutive cycles starting at cycle LATENCY+1.
- Flip bit 0 of share 1 of _QxDI for item 5 only -> MismatchxSO pulses once, ErrCntxDO=1, FailxSO=1, FirstErrXxDO equals item 5's X. A second injected error leaves the capture unchanged.
- Assert RstxBI low with 2 items in flight -> no CheckValidxSO pulse for those items and all counters are 0. Assert ClearxSI in the cycle an error completes -> ErrCntxDO=0 and FailxSO=0.
- CNT_W=2 with 5 injected errors -> ErrCntxDO saturates at 3.
